fir_tap_loader: RTL



---
 rtl/fir_pkg.sv | 23 ++
 rtl/fir_coef_bank.sv | 49 ++++
 rtl/fir_tap_loader.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR tap loader slice.
// Optional build macro: FIR_PRIME_ZERO_EN (start in RUN with a zero-filled window).
package fir_pkg;

  localparam int ORDER_DEF      = 8;
  localparam int DATA_WIDTH_DEF = 13;
  localparam int COEF_AW        = $clog2(ORDER_DEF + 1);

  typedef enum logic [1:0] {
    CFG   = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } fir_state_e;

  typedef logic signed [DATA_WIDTH_DEF-1:0] fir_sample_t;

  // Width needed to count 0..order+1.
  function automatic int fir_cnt_width(input int order);
    return $clog2(order + 2);
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient store: shadow bank written by address,
// copied to the active bank on commit with same-cycle write-through.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int ORDER      = ORDER_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int AW         = $clog2(ORDER + 1)
) (
  input  logic                         CLK,
  input  logic                         RST_n,
  input  logic                         we,
  input  logic [AW-1:0]                addr,
  input  logic signed [DATA_WIDTH-1:0] data,
  input  logic                         commit,
  output logic signed [DATA_WIDTH-1:0] h [0:ORDER]
);

  logic signed [DATA_WIDTH-1:0] shadow     [0:ORDER];
  logic signed [DATA_WIDTH-1:0] shadow_nxt [0:ORDER];
  logic                         addr_ok;

  assign addr_ok = (int'(addr) <= ORDER);

  // The commit copies shadow_nxt so a write in the commit cycle lands in H.
  always_comb begin
    for (int i = 0; i <= ORDER; i++) begin
      shadow_nxt[i] = shadow[i];
      if (we && addr_ok && (addr == AW'(i))) begin
        shadow_nxt[i] = data;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i <= ORDER; i++) begin
        shadow[i] <= '0;
        h[i]      <= '0;
      end
    end else begin
      shadow <= shadow_nxt;
      if (commit) begin
        h <= shadow_nxt;
      end
    end
  end

endmodule

// File: rtl/fir_tap_loader.sv
// Sample-window feeder for the FIR MAC: shift register, prime/drain FSM
// and coefficient bank. Build macro FIR_PRIME_ZERO_EN skips the PRIME fill.
//
// Handshake: a sample transfers on a rising CLK edge when DIN_VALID && DIN_READY;
// DIN_READY is combinational and never depends on DIN_VALID.
module fir_tap_loader
  import fir_pkg::*;
#(
  parameter int ORDER      = ORDER_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                           CLK,
  input  logic                           RST_n,
  input  logic signed [DATA_WIDTH-1:0]   DIN,
  input  logic                           DIN_VALID,
  output logic                           DIN_READY,
  input  logic                           COEF_WE,
  input  logic [$clog2(ORDER+1)-1:0]     COEF_ADDR,
  input  logic signed [DATA_WIDTH-1:0]   COEF_DATA,
  input  logic                           COEF_COMMIT,
  input  logic                           FLUSH,
  output logic signed [DATA_WIDTH-1:0]   TP_W [0:ORDER],
  output logic signed [DATA_WIDTH-1:0]   H    [0:ORDER],
  output logic                           WIN_VALID,
  output fir_state_e                     STATE_DBG
);

  localparam int AW    = $clog2(ORDER + 1);
  localparam int CNT_W = fir_cnt_width(ORDER);

  fir_state_e                   state, state_nxt;
  logic [CNT_W-1:0]             fill_cnt;
  logic [CNT_W-1:0]             drain_cnt;
  logic signed [DATA_WIDTH-1:0] tp [0:ORDER];

  logic accept;
  logic din_ready;
  logic shift_en;
  logic shift_zero;
  logic clear_win;
  logic clear_fill;
  logic win_set;
  logic commit_en;
  logic fill_last;
  logic drain_busy;

  assign fill_last  = (fill_cnt == CNT_W'(ORDER));
  assign drain_busy = (drain_cnt < CNT_W'(ORDER));
  assign accept     = DIN_VALID && din_ready;

  // State register
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state <= CFG;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      CFG: begin
        if (COEF_COMMIT) begin
`ifdef FIR_PRIME_ZERO_EN
          state_nxt = RUN;
`else
          state_nxt = PRIME;
`endif
        end
      end
      PRIME: begin
        if (accept && fill_last) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (FLUSH) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!drain_busy) begin
`ifdef FIR_PRIME_ZERO_EN
          state_nxt = RUN;
`else
          state_nxt = PRIME;
`endif
        end
      end
      default: state_nxt = CFG;
    endcase
  end

  // Output / control decode
  always_comb begin
    din_ready  = 1'b0;
    shift_en   = 1'b0;
    shift_zero = 1'b0;
    clear_win  = 1'b0;
    clear_fill = 1'b0;
    win_set    = 1'b0;
    commit_en  = 1'b0;
    case (state)
      CFG: begin
        commit_en = COEF_COMMIT;
      end
      PRIME: begin
        din_ready  = !COEF_COMMIT && !FLUSH;
        commit_en  = COEF_COMMIT;
        clear_win  = FLUSH;
        clear_fill = FLUSH;
        shift_en   = DIN_VALID && din_ready;
        win_set    = DIN_VALID && din_ready && fill_last;
      end
      RUN: begin
        din_ready = !COEF_COMMIT && !FLUSH;
        commit_en = COEF_COMMIT;
        shift_en  = DIN_VALID && din_ready;
        win_set   = DIN_VALID && din_ready;
      end
      DRAIN: begin
        // ORDER zero-shift cycles, then one cycle that clears the window
        // after the last drained window has been presented.
        if (drain_busy) begin
          shift_en   = 1'b1;
          shift_zero = 1'b1;
          win_set    = 1'b1;
        end else begin
          clear_win  = 1'b1;
          clear_fill = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      fill_cnt  <= '0;
      drain_cnt <= '0;
      WIN_VALID <= 1'b0;
    end else begin
      WIN_VALID <= win_set;
      if (clear_fill) begin
        fill_cnt <= '0;
      end else if (state == PRIME && accept) begin
        fill_cnt <= fill_cnt + 1'b1;
      end
      if (state == DRAIN) begin
        drain_cnt <= drain_cnt + 1'b1;
      end else begin
        drain_cnt <= '0;
      end
    end
  end

  // Tap shift register; tp[0] holds the newest sample.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i <= ORDER; i++) begin
        tp[i] <= '0;
      end
    end else if (clear_win) begin
      for (int i = 0; i <= ORDER; i++) begin
        tp[i] <= '0;
      end
    end else if (shift_en) begin
      tp[0] <= shift_zero ? '0 : DIN;
      for (int i = 1; i <= ORDER; i++) begin
        tp[i] <= tp[i-1];
      end
    end
  end

  fir_coef_bank #(
    .ORDER      (ORDER),
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (AW)
  ) u_coef_bank (
    .CLK    (CLK),
    .RST_n  (RST_n),
    .we     (COEF_WE),
    .addr   (COEF_ADDR),
    .data   (COEF_DATA),
    .commit (commit_en),
    .h      (H)
  );

  assign TP_W      = tp;
  assign DIN_READY = din_ready;
  assign STATE_DBG = state;

endmodule
